// File: rtl/piso_pkg.sv
// Shared types and width helpers for the PISO transmit controller.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Bit counter only has to reach WIDTH-1; never narrower than one bit.
  function automatic int bit_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

  // Gap counter has to reach GAP_CYCLES-1; kept at one bit when gaps are disabled.
  function automatic int gap_cnt_width(input int gap_cycles);
    return (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
  endfunction

endpackage

// File: rtl/piso_tx_ctrl_shreg.sv
// WIDTH-bit parallel-load shift register with zero fill; exposes the bit
// that goes out next on the serial line.
module piso_shreg #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             head
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load has priority so a back-to-back reload on the last bit wins over the shift.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) begin
        data_d = {data_q[WIDTH-2:0], 1'b0};
      end else begin
        data_d = {1'b0, data_q[WIDTH-1:1]};
      end
    end
  end

  // Register storage, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign head = (MSB_FIRST != 0) ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Frame controller for a PISO shift register: accepts words over
// valid/ready, shifts exactly WIDTH bits, then inserts an idle gap.
//
// state | meaning
// IDLE  | waiting for a word; din_ready high unless held or in reset
// SHIFT | one data bit per cycle on qout, frame high
// GAP   | forced idle cycles between frames, never accepts
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             hold,
  output logic             qout,
  output logic             qbarout,
  output logic             frame,
  output logic             last,
  output logic             busy
);

  localparam int BCW = bit_cnt_width(WIDTH);
  localparam int GCW = gap_cnt_width(GAP_CYCLES);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  state_e         state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
  logic           load;
  logic           shift_en;
  logic           head;
  logic           at_last;
  logic           accept;

  piso_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift_en(shift_en),
    .din     (din),
    .head    (head)
  );

  assign at_last = (bit_cnt_q == BIT_LAST);

  // Ready depends only on state, hold and reset so the source cannot form a loop through it.
  assign din_ready = !rst && !hold &&
                     ((state_q == IDLE) || ((state_q == SHIFT) && at_last && !HAS_GAP));
  assign accept    = din_valid && din_ready;

  // Next-state, counter and shift-register control; hold freezes everything.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          shift_en = 1'b1;
          if (at_last) begin
            bit_cnt_d = '0;
            if (HAS_GAP) begin
              gap_cnt_d = '0;
              state_d   = GAP;
            end else if (accept) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      GAP: begin
        if (!hold) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GCW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Serial outputs are decoded from registered state only, so reset clears them at once.
  assign qout    = (state_q == SHIFT) && head;
  assign qbarout = ~qout;
  assign frame   = (state_q == SHIFT);
  assign last    = (state_q == SHIFT) && at_last;
  assign busy    = (state_q != IDLE);

endmodule
